uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with an input word FIFO, runtime baud divisor and per-word framing control.
//  Each FIFO word (WORD_W bits) is serialised as consecutive UART characters.
//  Each character carries N data bits LSB-first. The last character is zero-padded.
//  Sits between the register/bus write path and the serial pin.
//  Adds buffering, a ready/valid handshake, a registered glitch-free output and back-to-back words with no idle gap.
// PARAMETERS
//  WORD_W   32  width of one FIFO word / host write
//  DEPTH    8   FIFO entries; power of two, >=2
//  DIV_W    16  width of baud divisor field
// PORTS
//  tick      in   1        clock; all state advances on posedge
//  rst       in   1        reset; asynchronous, active-low
//  csr       in   32       [3:0] N data bits, [4] 2 stop, [5] parity en, [6] odd parity, [31:16] baud div
//  wr_data   in   WORD_W   word to transmit
//  wr_valid  in   1        host offers wr_data
//  wr_ready  out  1        FIFO can accept (= !full); transfer when valid&ready at posedge
//  fifo_lvl  out  $clog2(DEPTH)+1  resident words
//  tx_busy   out  1        high whenever state != IDLE
//  tx_done   out  1        1-tick pulse after last stop bit of a word
//  out       out  1        serial line, registered, idle high
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, out=1, tx_done=0, tx_busy=0, FIFO empty, fifo_lvl=0, wr_ready=1.
//    Reset mid-frame aborts the frame immediately and drops all words, including the one in the shifter.
//  States: IDLE, START, DATA, PARITY, STOP1, STOP2. Each non-IDLE state lasts exactly DIV+1 ticks.
//    DIV=csr[31:16]; DIV=0 gives 1 tick per bit.
//  IDLE: if FIFO non-empty at posedge -> pop word into shifter, latch csr, go to START.
//    out=0 from that edge (latency 1 tick from a write into an empty FIFO).
//  START -> DATA. DATA shifts N bits, LSB first; a bit counter counts 0..N-1.
//    After bit N-1: -> PARITY if parity enabled, else -> STOP1.
//  PARITY: out = XOR of the N data bits; inverted when odd parity is selected.
//  STOP1 -> STOP2 if 2-stop is set; else treat as end of character. STOP2 -> end of character.
//  End of character:
//    - word bits remain (sent < WORD_W) -> START;
//    - word complete and FIFO non-empty -> pop, relatch csr, START (no idle tick), tx_done pulses;
//    - word complete and FIFO empty -> IDLE, tx_done pulses.
//  N rules: legal 5..8. csr[3:0] outside 5..8 is treated as 8.
//    Characters per word = ceil(WORD_W/N); pad bits are 0.
//  csr is latched per word; changes mid-word have no effect until the next pop.
//  FIFO: write and pop in the same tick are both honoured (level unchanged).
//    When full, wr_ready=0 and wr_valid is ignored. No overflow or underflow is possible.
//  fifo_lvl counts FIFO entries only, not the word held in the shifter.
// STRUCTURE
//  uart_pkg: state enum tx_state_e; csr bit/field localparams (CSR_NB, CSR_STOP2, CSR_PEN, CSR_PODD,
//    CSR_DIV_LSB); function eff_nbits().
//  Sub-module uart_sync_fifo #(WIDTH,DEPTH): ptr+1-bit full/empty, async active-low reset, level output.
//  Top holds the FSM, baud counter, bit/char counters, shifter, parity accumulator and output register.
// TESTING
//  1 WORD_W=8, 8N1, DIV=3, write 0xA5 -> out low 4 ticks, then 1,0,1,0,0,1,0,1 x4 ticks, stop high 4 ticks.
//    tx_done pulses at tick 41; tx_busy low after.
//  2 WORD_W=8, N=7, even parity, DIV=0, write 0x55 -> char1 data 1010101 parity 0; char2 data 0000000 parity 0.
//    Repeat with odd parity -> parity bits 1,1.
//  3 DEPTH=4, DIV=100, 6 back-to-back writes from idle -> 5 accepted (1 in shifter, 4 in FIFO).
//    wr_ready low, fifo_lvl=4; wr_ready high 1 tick after the next pop.
//  4 Two words queued, 8N2 -> stop2 of word 1 followed directly by start of word 2; tx_done pulses once per word.
//  5 rst low mid-DATA -> out=1, fifo_lvl=0, wr_ready=1 without waiting for a tick edge.
//    After release, a new write transmits cleanly.
//  6 Change csr[3:0] from 8 to 5 mid-word (WORD_W=32) -> current word keeps 4 chars of 8 bits.
//    Next word sends 7 chars of 5 bits with 3 pad zeros; csr[3:0]=2 -> treated as 8.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, csr field map and helpers for the UART transmitter
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } tx_state_e;

   // csr field positions
   localparam int CSR_NB      = 0;
   localparam int CSR_NB_W    = 4;
   localparam int CSR_STOP2   = 4;
   localparam int CSR_PEN     = 5;
   localparam int CSR_PODD    = 6;
   localparam int CSR_DIV_LSB = 16;

   // Character width actually used: anything outside 5..8 falls back to 8
   function automatic logic [3:0] eff_nbits(input logic [3:0] nb);
      if (nb >= 4'd5 && nb <= 4'd8) begin
         return nb;
      end
      return 4'd8;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through synchronous FIFO with level output
module uart_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_push_ok;
   logic             w_pop_ok;

   // Extra pointer MSB distinguishes full from empty when the index bits match
   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_level   = r_wptr - r_rptr;
   assign o_data    = r_mem[r_rptr[AW-1:0]];

   // A push while full and a pop while empty are silently dropped
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   // Storage array: written on accepted pushes only, no reset needed
   always_ff @(posedge i_clk) begin
      if (w_push_ok) begin
         r_mem[r_wptr[AW-1:0]] <= i_data;
      end
   end

   // Read/write pointers; simultaneous push and pop both advance
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + (AW+1)'(1);
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter serialising FIFO words into framed characters
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 8,
   parameter int DIV_W  = 16
) (
   input  logic                       i_tick,
   input  logic                       i_rst,
   input  logic [31:0]                i_csr,
   input  logic [WORD_W-1:0]          i_wr_data,
   input  logic                       i_wr_valid,
   output logic                       o_wr_ready,
   output logic [$clog2(DEPTH):0]     o_fifo_lvl,
   output logic                       o_tx_busy,
   output logic                       o_tx_done,
   output logic                       o_out
);

   localparam int BL_W = $clog2(WORD_W + 1);

   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [WORD_W-1:0] w_fifo_data;
   logic              w_pop;
   logic              w_bit_end;
   logic              w_last_bit;
   logic              w_word_done;
   logic              w_char_end;
   logic              w_csr_unused;

   tx_state_e         r_state;
   logic [DIV_W-1:0]  r_baud;
   logic [DIV_W-1:0]  r_div;
   logic [3:0]        r_nbits;
   logic              r_stop2;
   logic              r_pen;
   logic              r_podd;
   logic [3:0]        r_bit_cnt;
   logic [BL_W-1:0]   r_bits_left;
   logic [WORD_W-1:0] r_shift;
   logic              r_par;
   logic              r_out;
   logic              r_done;

   uart_sync_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_tick),
      .i_rst_n (i_rst),
      .i_push  (i_wr_valid),
      .i_data  (i_wr_data),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (o_fifo_lvl)
   );

   assign w_csr_unused = ^i_csr[CSR_DIV_LSB-1:CSR_PODD+1];

   // Bit period ends when the baud counter reaches the latched divisor
   assign w_bit_end   = (r_baud == r_div);
   assign w_last_bit  = (r_bit_cnt == r_nbits - 4'd1);
   // Pad bits are sent once every real word bit has left the shifter
   assign w_word_done = (r_bits_left == '0);
   assign w_char_end  = w_bit_end &&
                        ((r_state == ST_STOP2) || (r_state == ST_STOP1 && !r_stop2));
   // Pop from idle, or straight out of the final stop bit to avoid an idle gap
   assign w_pop       = !w_fifo_empty &&
                        ((r_state == ST_IDLE) || (w_char_end && w_word_done));

   assign o_wr_ready  = !w_fifo_full;
   assign o_tx_busy   = (r_state != ST_IDLE);
   assign o_tx_done   = r_done;
   assign o_out       = r_out;

   // Framing FSM with baud counter, shifter, parity accumulator and registered line output
   always_ff @(posedge i_tick or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= ST_IDLE;
         r_baud      <= '0;
         r_div       <= '0;
         r_nbits     <= 4'd8;
         r_stop2     <= 1'b0;
         r_pen       <= 1'b0;
         r_podd      <= 1'b0;
         r_bit_cnt   <= '0;
         r_bits_left <= '0;
         r_shift     <= '0;
         r_par       <= 1'b0;
         r_out       <= 1'b1;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;

         if (r_state != ST_IDLE) begin
            if (!w_bit_end) begin
               r_baud <= r_baud + DIV_W'(1);
            end else begin
               r_baud <= '0;
               case (r_state)
                  ST_START: begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= '0;
                     r_out     <= r_shift[0];
                     r_par     <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[WORD_W-1:1]};
                     if (!w_word_done) begin
                        r_bits_left <= r_bits_left - BL_W'(1);
                     end
                  end
                  ST_DATA: begin
                     if (w_last_bit) begin
                        if (r_pen) begin
                           r_state <= ST_PARITY;
                           r_out   <= r_par ^ r_podd;
                        end else begin
                           r_state <= ST_STOP1;
                           r_out   <= 1'b1;
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_out     <= r_shift[0];
                        r_par     <= r_par ^ r_shift[0];
                        r_shift   <= {1'b0, r_shift[WORD_W-1:1]};
                        if (!w_word_done) begin
                           r_bits_left <= r_bits_left - BL_W'(1);
                        end
                     end
                  end
                  ST_PARITY: begin
                     r_state <= ST_STOP1;
                     r_out   <= 1'b1;
                  end
                  ST_STOP1: begin
                     if (r_stop2) begin
                        r_state <= ST_STOP2;
                        r_out   <= 1'b1;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end

         // End of character: next character of the same word, or word complete
         if (w_char_end) begin
            if (!w_word_done) begin
               r_state <= ST_START;
               r_out   <= 1'b0;
            end else begin
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
               r_out   <= 1'b1;
            end
         end

         // Pop overrides the idle transition above so words run back-to-back
         if (w_pop) begin
            r_state     <= ST_START;
            r_out       <= 1'b0;
            r_baud      <= '0;
            r_shift     <= w_fifo_data;
            r_bits_left <= BL_W'(WORD_W);
            r_nbits     <= eff_nbits(i_csr[CSR_NB +: CSR_NB_W]);
            r_stop2     <= i_csr[CSR_STOP2];
            r_pen       <= i_csr[CSR_PEN];
            r_podd      <= i_csr[CSR_PODD];
            r_div       <= i_csr[CSR_DIV_LSB +: DIV_W];
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

   logic        clk;
   logic        rst_n;

   logic [31:0] a_csr;
   logic [7:0]  a_data;
   logic        a_valid;
   logic        a_ready;
   logic [2:0]  a_lvl;
   logic        a_busy;
   logic        a_done;
   logic        a_out;

   logic [31:0] b_csr;
   logic [31:0] b_data;
   logic        b_valid;
   logic        b_ready;
   logic [3:0]  b_lvl;
   logic        b_busy;
   logic        b_done;
   logic        b_out;

   int checks;
   int errors;

   bit          exp_q[$];
   int          done_edges[$];
   logic [31:0] words[$];
   logic [31:0] csrs[$];

   typedef struct {
      logic [31:0] csr;
      logic [7:0]  data;
      logic [31:0] bits;
      int          len;
   } vec_t;

   vec_t tbl[7];

   uart_tx_fifo #(.WORD_W(8), .DEPTH(4), .DIV_W(16)) u_dut_a (
      .i_tick     (clk),
      .i_rst      (rst_n),
      .i_csr      (a_csr),
      .i_wr_data  (a_data),
      .i_wr_valid (a_valid),
      .o_wr_ready (a_ready),
      .o_fifo_lvl (a_lvl),
      .o_tx_busy  (a_busy),
      .o_tx_done  (a_done),
      .o_out      (a_out)
   );

   uart_tx_fifo #(.WORD_W(32), .DEPTH(8), .DIV_W(16)) u_dut_b (
      .i_tick     (clk),
      .i_rst      (rst_n),
      .i_csr      (b_csr),
      .i_wr_data  (b_data),
      .i_wr_valid (b_valid),
      .o_wr_ready (b_ready),
      .o_fifo_lvl (b_lvl),
      .o_tx_busy  (b_busy),
      .o_tx_done  (b_done),
      .o_out      (b_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input bit sel, input logic [31:0] c, input logic [31:0] d, input logic v);
      if (sel) begin
         b_csr = c; b_data = d; b_valid = v;
      end else begin
         a_csr = c; a_data = d[7:0]; a_valid = v;
      end
   endtask

   function automatic logic get_out(input bit sel);
      return sel ? b_out : a_out;
   endfunction
   function automatic logic get_busy(input bit sel);
      return sel ? b_busy : a_busy;
   endfunction
   function automatic logic get_done(input bit sel);
      return sel ? b_done : a_done;
   endfunction

   task automatic push_rep(input bit b, input int reps);
      for (int r = 0; r < reps; r++) exp_q.push_back(b);
   endtask

   // Reference: expected line level per tick for one word, built from the framing rules
   task automatic add_word(input int ww, input logic [31:0] w, input logic [31:0] c);
      int n; int reps; int chars; int idx; bit b; bit par;
      n     = (c[3:0] >= 4'd5 && c[3:0] <= 4'd8) ? int'(c[3:0]) : 8;
      reps  = int'(c[31:16]) + 1;
      chars = (ww + n - 1) / n;
      for (int ch = 0; ch < chars; ch++) begin
         par = c[6];
         push_rep(1'b0, reps);
         for (int j = 0; j < n; j++) begin
            idx = ch * n + j;
            b   = (idx < ww) ? w[idx] : 1'b0;
            par = par ^ b;
            push_rep(b, reps);
         end
         if (c[5]) push_rep(par, reps);
         push_rep(1'b1, reps);
         if (c[4]) push_rep(1'b1, reps);
      end
      done_edges.push_back(1 + exp_q.size());
      words.push_back(w);
      csrs.push_back(c);
   endtask

   task automatic add_table(input int i);
      int reps;
      reps = int'(tbl[i].csr[31:16]) + 1;
      for (int k = 0; k < tbl[i].len; k++) push_rep(tbl[i].bits[k], reps);
      done_edges.push_back(1 + exp_q.size());
      words.push_back({24'd0, tbl[i].data});
      csrs.push_back(tbl[i].csr);
   endtask

   // Writes the queued words back-to-back from idle and compares every tick
   task automatic run_burst(input bit sel, input string nm);
      int total; int nxt; int pe;
      int bad_out; int bad_busy; int bad_done; int first_k;
      logic [31:0] cur_csr; logic [31:0] cur_data; logic cur_valid;
      logic got_o; bit e_out; bit e_busy; bit e_done;
      total = exp_q.size();
      nxt = 1; bad_out = 0; bad_busy = 0; bad_done = 0; first_k = -1;
      got_o = 1'b1; e_out = 1'b1;
      cur_csr = csrs[0]; cur_data = words[0]; cur_valid = 1'b1;
      set_in(sel, cur_csr, cur_data, cur_valid);
      for (int k = 0; k <= total + 3; k++) begin
         @(posedge clk); #1;
         cur_valid = (k + 1 < words.size());
         if (cur_valid) cur_data = words[k + 1];
         if (nxt < csrs.size()) begin
            pe = (nxt == 1) ? 1 : done_edges[nxt - 2];
            if (k == pe) begin
               cur_csr = csrs[nxt];
               nxt++;
            end
         end
         e_out  = (k >= 1 && k <= total) ? exp_q[k - 1] : 1'b1;
         e_busy = (k >= 1 && k <= total);
         e_done = 1'b0;
         foreach (done_edges[i]) if (done_edges[i] == k) e_done = 1'b1;
         if (get_out(sel) !== e_out) begin
            if (first_k < 0) begin
               first_k = k; got_o = get_out(sel);
            end
            bad_out++;
         end
         if (get_busy(sel) !== e_busy) bad_busy++;
         if (get_done(sel) !== e_done) bad_done++;
         set_in(sel, cur_csr, cur_data, cur_valid);
      end
      checks += 3;
      if (bad_out != 0) begin
         errors++;
         $display("FAIL %s out: %0d ticks wrong, first at tick %0d got %0b expected %0b",
                  nm, bad_out, first_k, got_o, exp_q[first_k - 1]);
      end
      if (bad_busy != 0) begin
         errors++;
         $display("FAIL %s busy: %0d ticks wrong, expected 0", nm, bad_busy);
      end
      if (bad_done != 0) begin
         errors++;
         $display("FAIL %s done: %0d ticks wrong, expected 0", nm, bad_done);
      end
      exp_q.delete(); done_edges.delete(); words.delete(); csrs.delete();
   endtask

   initial begin
      int acc; int w; bit sel; int ww; int kw; logic [31:0] wd; logic [31:0] c;
      checks = 0; errors = 0;

      // {csr, data, line bits in time order (bit i = i-th bit slot), slot count}
      tbl[0] = '{32'h0003_0008, 8'hA5, 32'h0000_034A, 10};
      tbl[1] = '{32'h0000_0027, 8'h55, 32'h0008_02AA, 20};
      tbl[2] = '{32'h0000_0067, 8'h55, 32'h000C_03AA, 20};
      tbl[3] = '{32'h0001_0018, 8'h3C, 32'h0000_0678, 11};
      tbl[4] = '{32'h0002_0035, 8'hFF, 32'h0003_9DFE, 18};
      tbl[5] = '{32'h0000_0002, 8'h81, 32'h0000_0302, 10};
      tbl[6] = '{32'h0001_006F, 8'h01, 32'h0000_0402, 11};

      rst_n = 1'b0;
      set_in(1'b0, 32'h0000_0008, 32'd0, 1'b0);
      set_in(1'b1, 32'h0000_0008, 32'd0, 1'b0);
      #12;
      chk("reset out a", a_out, 1);
      chk("reset busy a", a_busy, 0);
      chk("reset done a", a_done, 0);
      chk("reset lvl a", a_lvl, 0);
      chk("reset ready a", a_ready, 1);
      chk("reset out b", b_out, 1);
      chk("reset lvl b", b_lvl, 0);
      chk("reset ready b", b_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fill: one word goes to the shifter, four to the FIFO, sixth refused
      set_in(1'b0, 32'h0064_0008, 32'd0, 1'b0);
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         a_data = 8'h00; a_valid = 1'b1;
         if (a_ready) acc++;
         @(posedge clk); #1;
      end
      a_valid = 1'b0;
      chk("full accepted", acc, 5);
      chk("full ready", a_ready, 0);
      chk("full lvl", a_lvl, 4);
      chk("full busy", a_busy, 1);
      w = 0;
      while (a_lvl == 3'd4 && w < 1200) begin
         @(posedge clk); #1;
         w++;
      end
      chk("pop wait ticks", w, 1006);
      chk("pop lvl", a_lvl, 3);
      chk("pop ready", a_ready, 1);

      // Reset in the middle of a data bit of the second word
      for (int i = 0; i < 150; i++) begin
         @(posedge clk); #1;
      end
      chk("mid data out", a_out, 0);
      chk("mid data busy", a_busy, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async rst out", a_out, 1);
      chk("async rst lvl", a_lvl, 0);
      chk("async rst ready", a_ready, 1);
      chk("async rst busy", a_busy, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table vectors, first one directly after the reset
      for (int i = 0; i < 7; i++) begin
         add_table(i);
         run_burst(1'b0, $sformatf("vec%0d", i));
      end

      // Two queued words with two stop bits: no gap between them
      add_word(8, 32'h12, 32'h0001_0018);
      add_word(8, 32'h34, 32'h0001_0018);
      run_burst(1'b0, "8n2 pair");

      // csr changed mid-word only applies from the next pop
      add_word(32, 32'hDEAD_BEEF, 32'h0000_0008);
      add_word(32, 32'h1234_5678, 32'h0000_0005);
      add_word(32, 32'hCAFE_F00D, 32'h0000_0002);
      run_burst(1'b1, "csr mid-word");

      // Random words and framing on both widths
      for (int it = 0; it < 16; it++) begin
         sel = ((it % 2) == 1);
         ww  = sel ? 32 : 8;
         kw  = $urandom_range(1, 4);
         for (int j = 0; j < kw; j++) begin
            wd = $urandom;
            if (!sel) wd = wd & 32'h0000_00FF;
            c = $urandom;
            c[15:7]  = '0;
            c[31:16] = 16'($urandom_range(0, 3));
            add_word(ww, wd, c);
         end
         run_burst(sel, $sformatf("rand%0d", it));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
